// File: rtl/nibble_demux.sv
// Registered 1-to-2 demultiplexer for the shared operand bus: steers tagged transfers into two
// banks and presents a complete pair with a valid/ack handshake. Optional NIBBLE_DEMUX_TIMEOUT_EN.
module nibble_demux #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] D,
   input  logic             SEL,
   input  logic             DV,
   output logic             READY,
   output logic [WIDTH-1:0] Q1,
   output logic [WIDTH-1:0] Q0,
   output logic             PAIR_VALID,
   input  logic             ACK,
   output logic             OVERWRITE,
   output logic             TIMEOUT_ERR
);

   typedef enum logic [1:0] {StEmpty, StHave0, StHave1, StFull} state_e;

   state_e state;
   logic   accept;
   logic   timeout_hit;

   assign READY  = (state != StFull);
   assign accept = DV && READY;

`ifdef NIBBLE_DEMUX_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt;
   logic            partial;

   assign partial     = (state == StHave0) || (state == StHave1);
   // An accept on the expiry edge wins over the timeout.
   assign timeout_hit = partial && !accept && (cnt == CntW'(TIMEOUT - 1));

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt         <= '0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         TIMEOUT_ERR <= timeout_hit;
         if (!partial || accept || timeout_hit) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT;
   assign timeout_hit        = 1'b0;
   assign TIMEOUT_ERR        = 1'b0;
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= StEmpty;
         Q1         <= '0;
         Q0         <= '0;
         PAIR_VALID <= 1'b0;
         OVERWRITE  <= 1'b0;
      end else begin
         OVERWRITE <= 1'b0;
         if (accept) begin
            if (SEL) begin
               Q1 <= D;
            end else begin
               Q0 <= D;
            end
         end
         case (state)
            StEmpty: begin
               if (accept) begin
                  state <= SEL ? StHave1 : StHave0;
               end
            end
            StHave0: begin
               if (accept) begin
                  if (SEL) begin
                     state      <= StFull;
                     PAIR_VALID <= 1'b1;
                  end else begin
                     OVERWRITE <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  state <= StEmpty;
               end
            end
            StHave1: begin
               if (accept) begin
                  if (!SEL) begin
                     state      <= StFull;
                     PAIR_VALID <= 1'b1;
                  end else begin
                     OVERWRITE <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  state <= StEmpty;
               end
            end
            StFull: begin
               if (ACK) begin
                  state      <= StEmpty;
                  PAIR_VALID <= 1'b0;
               end
            end
            default: begin
               state      <= StEmpty;
               PAIR_VALID <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_demux.sv
// Bench for nibble_demux: directed scenarios plus random traffic against a bank-freshness model.
module tb_nibble_demux;

   localparam int unsigned W  = 4;
   localparam int unsigned TO = 16;
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         Clock = 1'b0;
   logic         Reset;
   logic [W-1:0] D;
   logic         SEL;
   logic         DV;
   logic         READY;
   logic [W-1:0] Q1;
   logic [W-1:0] Q0;
   logic         PAIR_VALID;
   logic         ACK;
   logic         OVERWRITE;
   logic         TIMEOUT_ERR;

   int checks   = 0;
   int failures = 0;

   // Model: freshness flag per bank, bank contents, pulses and idle-cycle count.
   bit         m_f0, m_f1;
   bit [W-1:0] m_q0, m_q1;
   bit         m_ov, m_terr;
   int         m_idle;

   nibble_demux #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .D          (D),
      .SEL        (SEL),
      .DV         (DV),
      .READY      (READY),
      .Q1         (Q1),
      .Q0         (Q0),
      .PAIR_VALID (PAIR_VALID),
      .ACK        (ACK),
      .OVERWRITE  (OVERWRITE),
      .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_f0 = 0; m_f1 = 0; m_q0 = '0; m_q1 = '0; m_ov = 0; m_terr = 0; m_idle = 0;
   endtask

   task automatic model_edge(input bit [W-1:0] d, input bit sel, input bit dv, input bit ack);
      bit full;
      full   = m_f0 && m_f1;
      m_ov   = 0;
      m_terr = 0;
      if (full) begin
         if (ack) begin
            m_f0 = 0; m_f1 = 0; m_idle = 0;
         end
      end else if (dv) begin
         if (sel) begin
            m_ov = m_f1; m_f1 = 1; m_q1 = d;
         end else begin
            m_ov = m_f0; m_f0 = 1; m_q0 = d;
         end
         m_idle = 0;
      end else if (m_f0 || m_f1) begin
         m_idle++;
         if (TO_EN && m_idle == TO) begin
            m_f0 = 0; m_f1 = 0; m_terr = 1; m_idle = 0;
         end
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".ready"}, READY, !(m_f0 && m_f1));
      chk({tag, ".pv"}, PAIR_VALID, m_f0 && m_f1);
      chk({tag, ".q0"}, Q0, m_q0);
      chk({tag, ".q1"}, Q1, m_q1);
      chk({tag, ".ov"}, OVERWRITE, m_ov);
      chk({tag, ".terr"}, TIMEOUT_ERR, m_terr);
   endtask

   // Drive one cycle of inputs, advance the model at the edge, then check 1 time unit later.
   task automatic step(input string tag, input bit [W-1:0] d, input bit sel, input bit dv,
                       input bit ack);
      D = d; SEL = sel; DV = dv; ACK = ack;
      @(posedge Clock);
      model_edge(d, sel, dv, ack);
      #1;
      chk_all(tag);
   endtask

   initial begin
      Reset = 1'b1; D = '0; SEL = 1'b0; DV = 1'b0; ACK = 1'b0;
      model_reset();
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b0;
      chk_all("reset");

      // Basic pair then ack.
      step("pair_a", 4'h3, 1'b0, 1'b1, 1'b0);
      step("pair_b", 4'hA, 1'b1, 1'b1, 1'b0);
      chk("pair_q0", Q0, 4'h3);
      chk("pair_q1", Q1, 4'hA);
      chk("pair_pv", PAIR_VALID, 1'b1);
      chk("pair_ready", READY, 1'b0);
      step("ack1", 4'h0, 1'b0, 1'b0, 1'b1);
      chk("ack1_pv", PAIR_VALID, 1'b0);
      chk("ack1_q", {Q1, Q0}, 8'hA3);

      // Back-pressure: DV held while full, then ack with DV still high.
      step("refill_a", 4'h3, 1'b0, 1'b1, 1'b0);
      step("refill_b", 4'hA, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step("bp_hold", 4'hF, 1'b0, 1'b1, 1'b0);
      chk("bp_banks", {Q1, Q0}, 8'hA3);
      step("bp_ack", 4'hF, 1'b0, 1'b1, 1'b1);
      chk("bp_ack_banks", {Q1, Q0}, 8'hA3);
      chk("bp_ack_ready", READY, 1'b1);
      step("bp_accept", 4'hF, 1'b0, 1'b1, 1'b0);
      chk("bp_accept_q0", Q0, 4'hF);
      step("bp_fill", 4'h1, 1'b1, 1'b1, 1'b0);
      step("bp_drain", 4'h0, 1'b0, 1'b0, 1'b1);

      // Overwrite of a fresh bank.
      step("ow_1", 4'h5, 1'b1, 1'b1, 1'b0);
      chk("ow_1_pulse", OVERWRITE, 1'b0);
      step("ow_2", 4'h6, 1'b1, 1'b1, 1'b0);
      chk("ow_2_pulse", OVERWRITE, 1'b1);
      step("ow_3", 4'h7, 1'b0, 1'b1, 1'b0);
      chk("ow_3_pulse", OVERWRITE, 1'b0);
      chk("ow_3_q", {Q1, Q0}, 8'h67);
      chk("ow_3_pv", PAIR_VALID, 1'b1);
      step("ow_drain", 4'h0, 1'b0, 1'b0, 1'b1);

      // Stray ack while empty and while partial.
      step("ack_empty", 4'h0, 1'b0, 1'b0, 1'b1);
      chk("ack_empty_pv", PAIR_VALID, 1'b0);
      step("to_have0", 4'h2, 1'b0, 1'b1, 1'b0);
      step("ack_have0", 4'h0, 1'b0, 1'b0, 1'b1);
      chk("ack_have0_pv", PAIR_VALID, 1'b0);
      chk("ack_have0_ready", READY, 1'b1);

`ifdef NIBBLE_DEMUX_TIMEOUT_EN
      step("to_load", 4'h9, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) step("to_idle", 4'h0, 1'b0, 1'b0, 1'b0);
      step("to_expire", 4'h0, 1'b0, 1'b0, 1'b0);
      chk("to_pulse", TIMEOUT_ERR, 1'b1);
      chk("to_q0_kept", Q0, 4'h9);
      step("to_after", 4'h0, 1'b0, 1'b0, 1'b0);
      chk("to_pulse_end", TIMEOUT_ERR, 1'b0);
      step("to_side1", 4'hB, 1'b1, 1'b1, 1'b0);
      chk("to_was_empty", PAIR_VALID, 1'b0);
      step("to_reset_ov", 4'hB, 1'b1, 1'b1, 1'b0);
      step("race_load", 4'h4, 1'b0, 1'b1, 1'b0);
      chk("race_pv0", PAIR_VALID, 1'b1);
      step("race_drain", 4'h0, 1'b0, 1'b0, 1'b1);
      step("race_p0", 4'h4, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) step("race_idle", 4'h0, 1'b0, 1'b0, 1'b0);
      step("race_accept", 4'h8, 1'b1, 1'b1, 1'b0);
      chk("race_no_err", TIMEOUT_ERR, 1'b0);
      chk("race_pv", PAIR_VALID, 1'b1);
      step("race_ack", 4'h0, 1'b0, 1'b0, 1'b1);
`else
      step("hold_load", 4'h9, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 100; i++) step("hold_idle", 4'h0, 1'b0, 1'b0, 1'b0);
      chk("hold_terr", TIMEOUT_ERR, 1'b0);
      step("hold_fill", 4'h8, 1'b1, 1'b1, 1'b0);
      chk("hold_pv", PAIR_VALID, 1'b1);
      chk("hold_q0", Q0, 4'h9);
      step("hold_ack", 4'h0, 1'b0, 1'b0, 1'b1);
`endif

      // Random traffic: busy phase then sparse phase that can let partial pairs age.
      for (int i = 0; i < 200; i++)
         step("rnd_busy", W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 300; i++)
         step("rnd_sparse", W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);

      // Asynchronous reset mid-cycle while data is held and DV is high.
      step("prerst_a", 4'hC, 1'b0, 1'b1, 1'b0);
      step("prerst_b", 4'hD, 1'b1, 1'b1, 1'b0);
      #2;
      DV = 1'b1; D = 4'hE; Reset = 1'b1;
      #1;
      model_reset();
      chk("async_ready", READY, 1'b1);
      chk("async_pv", PAIR_VALID, 1'b0);
      chk("async_q0", Q0, 4'h0);
      chk("async_q1", Q1, 4'h0);
      chk("async_ov", OVERWRITE, 1'b0);
      @(posedge Clock);
      #1 Reset = 1'b0;
      chk_all("post_rst");
      step("post_rst_acc", 4'hE, 1'b1, 1'b1, 1'b0);
      chk("post_rst_q1", Q1, 4'hE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
